// File: rtl/dvs_stream_pkg.sv
// Shared types and constants for the DVS frame readout path.
// A beat is one stream word together with its frame/line markers.
package dvs_stream_pkg;

    localparam int         H_RES_DEF = 320;
    localparam int         V_RES_DEF = 240;
    localparam int         FRAME_PIX = H_RES_DEF * V_RES_DEF;
    localparam logic [7:0] ALPHA     = 8'hFF;

    typedef struct packed {
        logic        last_of_frame;
        logic        tuser;
        logic        tlast;
        logic [31:0] tdata;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    function automatic logic [31:0] pack_tdata(input logic [9:0] ref_val, input logic [7:0] pix);
        return {ALPHA, 6'd0, ref_val, pix};
    endfunction

endpackage

// File: rtl/dvs_frame_readout_ctrl_if.sv
// AXI4-Stream video link carrying DVS pixels out of the frame buffer.
interface dvs_frame_readout_ctrl_if;

    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tuser;
    logic        tlast;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);

endinterface

// File: rtl/dvs_stream_fifo.sv
// Small first-word-fall-through FIFO of stream beats; the head is valid
// whenever count is non-zero and only moves on rd_en.
module dvs_stream_fifo
    import dvs_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             wr_en,
    input  beat_t            wr_data,
    input  logic             rd_en,
    output beat_t            head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    beat_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is cleared on reset so the stream data reads as zero after an abort.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/dvs_frame_readout_ctrl.sv
// Streams one DVS frame from the frame buffer to an AXI4-Stream master,
// credit-limiting buffer reads so the output FIFO can never overflow.
//
// state  | meaning
// IDLE   | waiting for frame_req
// STREAM | issuing buffer reads, one per cycle while credit allows
// FLUSH  | all reads issued, draining FIFO until the last beat is accepted
module dvs_frame_readout_ctrl
    import dvs_stream_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int ADDR_W     = 17,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      pclk,
    input  logic                      reset,
    input  logic                      frame_req,
    output logic                      buf_rd_en,
    output logic [ADDR_W-1:0]         buf_addr,
    input  logic [7:0]                buf_pix,
    input  logic [9:0]                buf_ref,
    dvs_frame_readout_ctrl_if.master  m_axis,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      req_dropped
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int USE_W = CNT_W + 1;
    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_RES - 1);

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             pending;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [RD_LAT-1:0] pipe_vld;
    logic [2:0]       pipe_sb [RD_LAT];
    beat_t            fifo_wr_data;
    beat_t            head;
    logic             land;
    logic             pop;
    logic [USE_W-1:0] used_next;
    logic             credit_ok;

    assign land = pipe_vld[RD_LAT-1];
    assign pop  = m_axis.tvalid & m_axis.tready;

    // Read strobe is registered, so credit is judged on next cycle's occupancy;
    // landing data just moves from inflight to the FIFO and nets out.
    assign used_next = USE_W'(fifo_count) + USE_W'(inflight) + USE_W'(buf_rd_en) - USE_W'(pop);
    assign credit_ok = (used_next < USE_W'(FIFO_DEPTH));

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_sb[i] <= '0;
        end else begin
            pipe_vld[0] <= buf_rd_en;
            pipe_sb[0]  <= {buf_addr == LAST_ADDR, buf_addr == '0, col == COL_LAST};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_sb[i]  <= pipe_sb[i-1];
            end
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            case ({buf_rd_en, land})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        fifo_wr_data               = '0;
        fifo_wr_data.last_of_frame = pipe_sb[RD_LAT-1][2];
        fifo_wr_data.tuser         = pipe_sb[RD_LAT-1][1];
        fifo_wr_data.tlast         = pipe_sb[RD_LAT-1][0];
        fifo_wr_data.tdata         = pack_tdata(buf_ref, buf_pix);
    end

    dvs_stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pclk    (pclk),
        .reset   (reset),
        .wr_en   (land),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .head    (head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            buf_rd_en <= 1'b0;
            buf_addr  <= '0;
            col       <= '0;
            row       <= '0;
            pending   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_req) begin
                        state     <= STREAM;
                        buf_rd_en <= 1'b1;
                        buf_addr  <= '0;
                        col       <= '0;
                        row       <= '0;
                    end
                end
                STREAM: begin
                    if (buf_rd_en && buf_addr == LAST_ADDR) begin
                        state     <= FLUSH;
                        buf_rd_en <= 1'b0;
                    end else begin
                        buf_rd_en <= credit_ok;
                        if (buf_rd_en) begin
                            buf_addr <= buf_addr + 1'b1;
                            if (col == COL_LAST) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                FLUSH: begin
                    buf_rd_en <= 1'b0;
                    // A request landing on the done cycle counts as already pending.
                    if (frame_done) begin
                        if (pending || frame_req) begin
                            state     <= STREAM;
                            buf_rd_en <= 1'b1;
                            buf_addr  <= '0;
                            col       <= '0;
                            row       <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (state != IDLE) begin
                if (frame_done)     pending <= pending & frame_req;
                else if (frame_req) pending <= 1'b1;
            end
        end
    end

    assign m_axis.tvalid = ~fifo_empty;
    assign m_axis.tdata  = head.tdata;
    assign m_axis.tuser  = head.tuser;
    assign m_axis.tlast  = head.tlast;

    assign busy        = (state != IDLE);
    assign frame_done  = pop & head.last_of_frame;
    assign req_dropped = frame_req & pending & ~frame_done;

endmodule

// File: tb/tb_dvs_frame_readout_ctrl.sv
// Directed bench for dvs_frame_readout_ctrl: small 4x3 frames at read latency
// 1 and 2, plus one full-size default frame.
module tb_dvs_frame_readout_ctrl;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        reset;
    logic        req_a, req_b, req_f;
    logic        rd_a, rd_b, rd_f;
    logic [16:0] addr_a, addr_b, addr_f;
    logic [7:0]  pix_a, pix_b, pix_b1, pix_f;
    logic [9:0]  ref_a, ref_b, ref_b1, ref_f;
    logic        busy_a, busy_b, busy_f;
    logic        done_a, done_b, done_f;
    logic        drop_a, drop_b, drop_f;

    int n_tests = 0;
    int n_fail  = 0;

    dvs_frame_readout_ctrl_if ax_a ();
    dvs_frame_readout_ctrl_if ax_b ();
    dvs_frame_readout_ctrl_if ax_f ();

    function automatic logic [7:0] pix_of(input logic [16:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [9:0] ref_of(input logic [16:0] a);
        logic [16:0] t;
        t = a * 17'd3 + 17'd7;
        return t[9:0];
    endfunction

    function automatic logic [31:0] exp_data(input logic [16:0] a);
        return {8'hFF, 6'd0, ref_of(a), pix_of(a)};
    endfunction

    // Frame buffer models: one registered stage for RD_LAT=1, two for RD_LAT=2.
    always @(posedge pclk) begin
        if (rd_a) begin pix_a <= pix_of(addr_a); ref_a <= ref_of(addr_a); end
        if (rd_b) begin pix_b1 <= pix_of(addr_b); ref_b1 <= ref_of(addr_b); end
        pix_b <= pix_b1;
        ref_b <= ref_b1;
        if (rd_f) begin pix_f <= pix_of(addr_f); ref_f <= ref_of(addr_f); end
    end

    dvs_frame_readout_ctrl #(.H_RES(4), .V_RES(3), .ADDR_W(17), .RD_LAT(1), .FIFO_DEPTH(4)) u_a (
        .pclk(pclk), .reset(reset), .frame_req(req_a), .buf_rd_en(rd_a), .buf_addr(addr_a),
        .buf_pix(pix_a), .buf_ref(ref_a), .m_axis(ax_a), .busy(busy_a), .frame_done(done_a),
        .req_dropped(drop_a));

    dvs_frame_readout_ctrl #(.H_RES(4), .V_RES(3), .ADDR_W(17), .RD_LAT(2), .FIFO_DEPTH(4)) u_b (
        .pclk(pclk), .reset(reset), .frame_req(req_b), .buf_rd_en(rd_b), .buf_addr(addr_b),
        .buf_pix(pix_b), .buf_ref(ref_b), .m_axis(ax_b), .busy(busy_b), .frame_done(done_b),
        .req_dropped(drop_b));

    dvs_frame_readout_ctrl u_f (
        .pclk(pclk), .reset(reset), .frame_req(req_f), .buf_rd_en(rd_f), .buf_addr(addr_f),
        .buf_pix(pix_f), .buf_ref(ref_f), .m_axis(ax_f), .busy(busy_f), .frame_done(done_f),
        .req_dropped(drop_f));

    task automatic test_reset();
        reset = 1'b0;
        req_a = 1'b0; req_b = 1'b0; req_f = 1'b0;
        ax_a.tready = 1'b0; ax_b.tready = 1'b0; ax_f.tready = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        n_tests++; if (ax_a.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", ax_a.tvalid); end
        n_tests++; if (ax_a.tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", ax_a.tdata); end
        n_tests++; if (ax_a.tuser !== 1'b0 || ax_a.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_side: got user=%b last=%b want 0/0", ax_a.tuser, ax_a.tlast); end
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_tests++; if (rd_a !== 1'b0 || addr_a !== 17'd0) begin n_fail++; $display("FAIL reset_rd: got rd=%b addr=%0d want 0/0", rd_a, addr_a); end
        n_tests++; if (done_a !== 1'b0 || drop_a !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b drop=%b want 0/0", done_a, drop_a); end
        n_tests++; if (ax_b.tvalid !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_b: got tvalid=%b busy=%b want 0/0", ax_b.tvalid, busy_b); end
        n_tests++; if (ax_f.tvalid !== 1'b0 || busy_f !== 1'b0) begin n_fail++; $display("FAIL reset_f: got tvalid=%b busy=%b want 0/0", ax_f.tvalid, busy_f); end
        @(posedge pclk); #1;
        reset = 1'b1;
    endtask

    task automatic test_single_frame();
        int b;
        ax_a.tready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            @(posedge pclk); #1;
            req_a = (c == 0);
            @(negedge pclk);
            if (c == 0) begin
                n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy0: got %b want 0", busy_a); end
            end
            if (c == 1) begin
                n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy1: got %b want 1", busy_a); end
                n_tests++; if (rd_a !== 1'b1 || addr_a !== 17'd0) begin n_fail++; $display("FAIL single_first_rd: got rd=%b addr=%0d want 1/0", rd_a, addr_a); end
            end
            if (c < 3) begin
                n_tests++; if (ax_a.tvalid !== 1'b0) begin n_fail++; $display("FAIL single_early_tvalid c%0d: got %b want 0", c, ax_a.tvalid); end
            end else if (c < 15) begin
                b = c - 3;
                n_tests++; if (ax_a.tvalid !== 1'b1) begin n_fail++; $display("FAIL single_tvalid b%0d: got %b want 1", b, ax_a.tvalid); end
                n_tests++; if (ax_a.tdata !== exp_data(17'(b))) begin n_fail++; $display("FAIL single_tdata b%0d: got %h want %h", b, ax_a.tdata, exp_data(17'(b))); end
                n_tests++; if (ax_a.tuser !== (b == 0) || ax_a.tlast !== ((b % 4) == 3)) begin n_fail++; $display("FAIL single_side b%0d: got user=%b last=%b want %b/%b", b, ax_a.tuser, ax_a.tlast, b == 0, (b % 4) == 3); end
                n_tests++; if (done_a !== (b == 11)) begin n_fail++; $display("FAIL single_done b%0d: got %b want %b", b, done_a, b == 11); end
            end else begin
                n_tests++; if (ax_a.tvalid !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL single_end c%0d: got tvalid=%b busy=%b want 0/0", c, ax_a.tvalid, busy_a); end
            end
        end
    endtask

    task automatic test_backpressure();
        int issued, popped, occ, max_occ, dones;
        logic        stalled;
        logic [31:0] hold_data;
        logic        hold_user, hold_last;
        issued = 0; popped = 0; max_occ = 0; dones = 0; stalled = 1'b0;
        hold_data = '0; hold_user = 1'b0; hold_last = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge pclk); #1;
            req_a = (c == 0);
            ax_a.tready = ((c % 4) == 0) || ((c % 4) == 3);
            @(negedge pclk);
            if (stalled) begin
                n_tests++;
                if (ax_a.tvalid !== 1'b1 || ax_a.tdata !== hold_data || ax_a.tuser !== hold_user || ax_a.tlast !== hold_last) begin
                    n_fail++; $display("FAIL bp_hold c%0d: got v=%b d=%h u=%b l=%b want 1/%h/%b/%b", c, ax_a.tvalid, ax_a.tdata, ax_a.tuser, ax_a.tlast, hold_data, hold_user, hold_last);
                end
            end
            if (rd_a === 1'b1) begin
                n_tests++; if (addr_a !== 17'(issued)) begin n_fail++; $display("FAIL bp_addr: got %0d want %0d", addr_a, issued); end
            end
            occ = issued + int'(rd_a === 1'b1) - popped;
            if (occ > max_occ) max_occ = occ;
            if (rd_a === 1'b1) issued++;
            if (done_a === 1'b1) dones++;
            if (ax_a.tvalid === 1'b1 && ax_a.tready === 1'b1) begin
                n_tests++; if (ax_a.tdata !== exp_data(17'(popped))) begin n_fail++; $display("FAIL bp_tdata beat%0d: got %h want %h", popped, ax_a.tdata, exp_data(17'(popped))); end
                n_tests++; if (ax_a.tuser !== (popped == 0) || ax_a.tlast !== ((popped % 4) == 3)) begin n_fail++; $display("FAIL bp_side beat%0d: got u=%b l=%b", popped, ax_a.tuser, ax_a.tlast); end
                n_tests++; if (done_a !== (popped == 11)) begin n_fail++; $display("FAIL bp_done beat%0d: got %b want %b", popped, done_a, popped == 11); end
                popped++;
            end
            stalled   = (ax_a.tvalid === 1'b1) && (ax_a.tready === 1'b0);
            hold_data = ax_a.tdata;
            hold_user = ax_a.tuser;
            hold_last = ax_a.tlast;
        end
        ax_a.tready = 1'b1;
        n_tests++; if (popped != 12) begin n_fail++; $display("FAIL bp_beats: got %0d want 12", popped); end
        n_tests++; if (issued != 12) begin n_fail++; $display("FAIL bp_reads: got %0d want 12", issued); end
        n_tests++; if (dones != 1) begin n_fail++; $display("FAIL bp_dones: got %0d want 1", dones); end
        n_tests++; if (max_occ > 4) begin n_fail++; $display("FAIL bp_occupancy: got %0d want <=4", max_occ); end
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end: got %b want 0", busy_a); end
    endtask

    task automatic test_pending();
        int b, drops;
        drops = 0;
        ax_a.tready = 1'b1;
        for (int c = 0; c < 34; c++) begin
            @(posedge pclk); #1;
            req_a = (c == 0) || (c == 5) || (c == 8);
            @(negedge pclk);
            if (drop_a === 1'b1) drops++;
            if (c == 5 || c == 8) begin
                n_tests++; if (drop_a !== (c == 8)) begin n_fail++; $display("FAIL pend_drop c%0d: got %b want %b", c, drop_a, c == 8); end
            end
            if (c == 14 || c == 28) begin
                n_tests++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL pend_done c%0d: got %b want 1", c, done_a); end
            end
            if (c == 15 || c == 16) begin
                n_tests++; if (ax_a.tvalid !== 1'b0) begin n_fail++; $display("FAIL pend_gap c%0d: got %b want 0", c, ax_a.tvalid); end
            end
            if (c >= 17 && c < 29) begin
                b = c - 17;
                n_tests++;
                if (ax_a.tvalid !== 1'b1 || ax_a.tdata !== exp_data(17'(b)) || ax_a.tuser !== (b == 0)) begin
                    n_fail++; $display("FAIL pend_frame2 b%0d: got v=%b d=%h u=%b want 1/%h/%b", b, ax_a.tvalid, ax_a.tdata, ax_a.tuser, exp_data(17'(b)), b == 0);
                end
            end
            if (c == 30) begin
                n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL pend_idle: got busy=%b want 0", busy_a); end
            end
            if (c == 33) begin
                n_tests++; if (ax_a.tvalid !== 1'b0) begin n_fail++; $display("FAIL pend_no_third: got tvalid=%b want 0", ax_a.tvalid); end
            end
        end
        n_tests++; if (drops != 1) begin n_fail++; $display("FAIL pend_drop_count: got %0d want 1", drops); end
    endtask

    task automatic test_req_at_done();
        ax_a.tready = 1'b1;
        for (int c = 0; c < 31; c++) begin
            @(posedge pclk); #1;
            req_a = (c == 0) || (c == 14);
            @(negedge pclk);
            if (c == 14) begin
                n_tests++; if (done_a !== 1'b1 || drop_a !== 1'b0) begin n_fail++; $display("FAIL rad_done: got done=%b drop=%b want 1/0", done_a, drop_a); end
            end
            if (c == 17) begin
                n_tests++;
                if (ax_a.tvalid !== 1'b1 || ax_a.tuser !== 1'b1 || ax_a.tdata !== exp_data(17'd0)) begin
                    n_fail++; $display("FAIL rad_restart: got v=%b u=%b d=%h want 1/1/%h", ax_a.tvalid, ax_a.tuser, ax_a.tdata, exp_data(17'd0));
                end
            end
            if (c == 28) begin
                n_tests++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL rad_done2: got %b want 1", done_a); end
            end
            if (c == 30) begin
                n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rad_idle: got busy=%b want 0", busy_a); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int c = 0; c < 37; c++) begin
            @(posedge pclk); #1;
            req_a = (c == 0) || (c == 21);
            ax_a.tready = !(c >= 9 && c <= 11);
            if (c == 10) reset = 1'b0;
            if (c == 12) reset = 1'b1;
            @(negedge pclk);
            if (c == 9) begin
                n_tests++; if (ax_a.tvalid !== 1'b1 || ax_a.tdata !== exp_data(17'd6)) begin n_fail++; $display("FAIL rst_stall: got v=%b d=%h want 1/%h", ax_a.tvalid, ax_a.tdata, exp_data(17'd6)); end
            end
            if (c == 10) begin
                n_tests++; if (ax_a.tvalid !== 1'b0 || ax_a.tdata !== 32'h0) begin n_fail++; $display("FAIL rst_abort_data: got v=%b d=%h want 0/0", ax_a.tvalid, ax_a.tdata); end
                n_tests++; if (ax_a.tuser !== 1'b0 || ax_a.tlast !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_abort_side: got u=%b l=%b busy=%b want 0/0/0", ax_a.tuser, ax_a.tlast, busy_a); end
                n_tests++; if (rd_a !== 1'b0 || addr_a !== 17'd0) begin n_fail++; $display("FAIL rst_abort_rd: got rd=%b addr=%0d want 0/0", rd_a, addr_a); end
            end
            if (c >= 12 && c < 24) begin
                n_tests++; if (ax_a.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_quiet c%0d: got tvalid=%b want 0", c, ax_a.tvalid); end
            end
            if (c == 24) begin
                n_tests++;
                if (ax_a.tvalid !== 1'b1 || ax_a.tuser !== 1'b1 || ax_a.tdata !== exp_data(17'd0)) begin
                    n_fail++; $display("FAIL rst_restart: got v=%b u=%b d=%h want 1/1/%h", ax_a.tvalid, ax_a.tuser, ax_a.tdata, exp_data(17'd0));
                end
            end
            if (c == 35) begin
                n_tests++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL rst_done: got %b want 1", done_a); end
            end
            if (c == 36) begin
                n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got busy=%b want 0", busy_a); end
            end
        end
    endtask

    task automatic test_rd_lat2();
        int b;
        ax_b.tready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            @(posedge pclk); #1;
            req_b = (c == 0);
            @(negedge pclk);
            if (c < 4) begin
                n_tests++; if (ax_b.tvalid !== 1'b0) begin n_fail++; $display("FAIL lat2_early c%0d: got %b want 0", c, ax_b.tvalid); end
            end else if (c < 16) begin
                b = c - 4;
                n_tests++;
                if (ax_b.tvalid !== 1'b1 || ax_b.tdata !== exp_data(17'(b)) || ax_b.tuser !== (b == 0) || ax_b.tlast !== ((b % 4) == 3)) begin
                    n_fail++; $display("FAIL lat2_beat b%0d: got v=%b d=%h u=%b l=%b want 1/%h", b, ax_b.tvalid, ax_b.tdata, ax_b.tuser, ax_b.tlast, exp_data(17'(b)));
                end
                n_tests++; if (done_b !== (b == 11)) begin n_fail++; $display("FAIL lat2_done b%0d: got %b want %b", b, done_b, b == 11); end
            end else begin
                n_tests++; if (ax_b.tvalid !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL lat2_end: got v=%b busy=%b want 0/0", ax_b.tvalid, busy_b); end
            end
        end
    endtask

    task automatic test_full_frame();
        int beats, lasts, users, bad, max_addr;
        logic seen_done;
        beats = 0; lasts = 0; users = 0; bad = 0; max_addr = 0; seen_done = 1'b0;
        ax_f.tready = 1'b1;
        for (int c = 0; c < 78000 && !seen_done; c++) begin
            @(posedge pclk); #1;
            req_f = (c == 0);
            @(negedge pclk);
            if (rd_f === 1'b1 && int'(addr_f) > max_addr) max_addr = int'(addr_f);
            if (ax_f.tvalid === 1'b1) begin
                if (ax_f.tdata !== exp_data(17'(beats)) || ax_f.tuser !== (beats == 0) || ax_f.tlast !== ((beats % 320) == 319)) begin
                    if (bad == 0) $display("[TB] full frame first bad beat %0d: d=%h want %h", beats, ax_f.tdata, exp_data(17'(beats)));
                    bad++;
                end
                if (ax_f.tlast === 1'b1) lasts++;
                if (ax_f.tuser === 1'b1) users++;
                beats++;
            end
            if (done_f === 1'b1) seen_done = 1'b1;
        end
        req_f = 1'b0;
        n_tests++; if (seen_done !== 1'b1) begin n_fail++; $display("FAIL full_timeout: frame_done seen=%b want 1", seen_done); end
        n_tests++; if (beats != 76800) begin n_fail++; $display("FAIL full_beats: got %0d want 76800", beats); end
        n_tests++; if (lasts != 240) begin n_fail++; $display("FAIL full_tlast: got %0d want 240", lasts); end
        n_tests++; if (users != 1) begin n_fail++; $display("FAIL full_tuser: got %0d want 1", users); end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL full_data: got %0d bad beats want 0", bad); end
        n_tests++; if (max_addr != 76799) begin n_fail++; $display("FAIL full_max_addr: got %0d want 76799", max_addr); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_pending();
        test_req_at_done();
        test_reset_mid_frame();
        test_rd_lat2();
        test_full_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dvs_frame_readout_ctrl.md
Name: dvs_frame_readout_ctrl

Overview:
Sequences readout of one 320x240 DVS frame from the dual-port frame buffer (pixel byte plus 10-bit reference per address) into an AXI4-Stream video master with full tready backpressure. The block generates buffer read addresses, absorbs the buffer's fixed read latency in a small output FIFO, and marks start-of-frame (tuser) and end-of-line (tlast). It sits between the camera write side of the frame buffer and the AXI VDMA/stream sink.

Parameters:
H_RES, 320, pixels per line
V_RES, 240, lines per frame
ADDR_W, 17, frame buffer address width
RD_LAT, 1, frame buffer read latency in cycles (1 or 2)
FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+2

Ports:
pclk  in  1  single clock for all logic
reset  in  1  asynchronous active-low reset (0 = reset asserted)
frame_req  in  1  single-cycle request to stream one frame
buf_rd_en  out  1  frame buffer read strobe
buf_addr  out  ADDR_W  frame buffer read address
buf_pix  in  8  read data: pixel, valid RD_LAT cycles after buf_rd_en
buf_ref  in  10  read data: reference, same timing as buf_pix
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tdata  out  32  {8'hFF, 6'd0, ref[9:0], pix[7:0]}
m_axis_tuser  out  1  start of frame, first beat only
m_axis_tlast  out  1  last beat of each line
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse when last beat is accepted
req_dropped  out  1  one-cycle pulse when a request is discarded

Behaviour:
- Reset (reset==0, async): state IDLE; buf_rd_en=0, buf_addr=0, FIFO empty, m_axis_tvalid=0, tdata=0, tuser=0, tlast=0, busy=0, frame_done=0, req_dropped=0, pending=0, counters 0. Reset mid-frame aborts immediately; no partial beats are presented after release.
- FSM states: IDLE, STREAM, FLUSH.
  - IDLE: on frame_req go to STREAM next cycle, with buf_addr=0 and col=row=0. A request arriving while pending=1 is ignored.
  - STREAM: issue a read whenever fifo_count + inflight < FIFO_DEPTH. Each read increments buf_addr; col wraps at H_RES-1 and increments row. After issuing address H_RES*V_RES-1 (76799), go to FLUSH.
  - FLUSH: no reads. When the last beat handshakes (tvalid&tready with sideband last_of_frame): pulse frame_done. Then go to STREAM if pending=1 (clearing pending) or to IDLE otherwise.
- Requests while busy: the first request sets pending=1. Any request while pending=1 pulses req_dropped. A request in the same cycle as frame_done is captured as pending.
- The sideband is computed at issue time and carried through the RD_LAT pipe into the FIFO with the data:
  - tuser = (buf_addr==0)
  - tlast = (col==H_RES-1)
  - last_of_frame = final address
- Inflight counter: +1 on issue, -1 when data lands in the FIFO. Simultaneous issue and land leave it unchanged.
- FIFO write occurs RD_LAT cycles after issue. FIFO read occurs on tvalid&tready.
  - Simultaneous read and write leave the count unchanged.
  - FIFO never overflows, by the credit rule above.
- m_axis_tvalid = FIFO not empty. tdata, tuser and tlast come from the FIFO head and must hold stable while tvalid=1 and tready=0.
- Throughput: 1 beat/cycle sustained with tready=1.
- Latency: frame_req to first tvalid = 1 + 1 + RD_LAT cycles.
- busy = (state != IDLE).

Decomposition:
- Package dvs_stream_pkg:
  - H_RES_DEF=320, V_RES_DEF=240, FRAME_PIX=76800
  - ALPHA=8'hFF
  - beat typedef {last_of_frame, tuser, tlast, tdata[31:0]}
  - FSM state enum
- Sub-module dvs_stream_fifo: a synchronous FIFO on the beat type with count output and first-word-fall-through head.

Test Plan:
- Single frame, tready=1, RD_LAT=1, H_RES=4, V_RES=3:
  - frame_req at cycle 0 -> first tvalid at cycle 3 with tuser=1, tdata=32'hFF00_0000|{ref,pix} of addr 0.
  - 12 beats back-to-back; tlast on beats 3, 7, 11.
  - frame_done pulses in the cycle beat 11 is accepted.
- Backpressure: tready toggles 1,0,0,1 repeating -> no beat lost or duplicated; tdata stable while stalled; addresses 0..11 appear in order; inflight+fifo_count never exceeds 4.
- Requests while busy: second frame_req mid-frame -> pending set, next frame's tuser beat follows the frame_done cycle. A third request pulses req_dropped=1.
- Full size with defaults: 76800 beats, 240 tlast pulses, exactly one tuser; buf_addr never exceeds 76799.
- Reset asserted (reset=0) after beat 5 with tready=0 -> outputs zero immediately. After release, no beats until a new frame_req; the next frame starts at addr 0 with tuser=1.
- RD_LAT=2, FIFO_DEPTH=4, tready=1 -> first tvalid 4 cycles after frame_req; full-rate stream thereafter.
